// File: rtl/drm_8x1024_arb.sv
// Two-requester arbiter in front of a simple dual-port RAM (one write port, one read port).
// Each RAM port has its own round-robin arbiter; read data returns two cycles after the grant.
module drm_8x1024_arb #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_byte_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  logic                  wreq0, wreq1, rreq0, rreq1;
  logic                  wgnt0, wgnt1, rgnt0, rgnt1;
  logic                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rv1_q, rv1_d, own1_q, own1_d;
  logic                  rv2_q, rv2_d, own2_q, own2_d;

  always_comb begin
    wreq0 = rst_n & req0 & we0;
    wreq1 = rst_n & req1 & we1;
    // pointer names the last winner; on contention the other requester wins
    wgnt0 = wreq0 & (~wreq1 | wptr_q);
    wgnt1 = wreq1 & (~wreq0 | ~wptr_q);

    // a read of the address being written this cycle waits, so it returns the new data
    rreq0 = rst_n & req0 & ~we0 & ~(wgnt1 & (addr1 == addr0));
    rreq1 = rst_n & req1 & ~we1 & ~(wgnt0 & (addr0 == addr1));
    rgnt0 = rreq0 & (~rreq1 | rptr_q);
    rgnt1 = rreq1 & (~rreq0 | ~rptr_q);

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = wgnt0 | wgnt1;

    if (wgnt0) begin
      wptr_d    = 1'b0;
      wr_addr_d = addr0;
      wr_data_d = wdata0;
    end else if (wgnt1) begin
      wptr_d    = 1'b1;
      wr_addr_d = addr1;
      wr_data_d = wdata1;
    end

    if (rgnt0) begin
      rptr_d    = 1'b0;
      rd_addr_d = addr0;
    end else if (rgnt1) begin
      rptr_d    = 1'b1;
      rd_addr_d = addr1;
    end

    rv1_d  = rgnt0 | rgnt1;
    own1_d = rgnt1;
    rv2_d  = rv1_q;
    own2_d = own1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= 1'b1;
      rptr_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      rv1_q     <= 1'b0;
      own1_q    <= 1'b0;
      rv2_q     <= 1'b0;
      own2_q    <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      rv1_q     <= rv1_d;
      own1_q    <= own1_d;
      rv2_q     <= rv2_d;
      own2_q    <= own2_d;
    end
  end

  assign gnt0           = wgnt0 | rgnt0;
  assign gnt1           = wgnt1 | rgnt1;
  assign rvalid0        = rv2_q & ~own2_q;
  assign rvalid1        = rv2_q & own2_q;
  assign rdata0         = rvalid0 ? ram_rd_data : '0;
  assign rdata1         = rvalid1 ? ram_rd_data : '0;
  assign ram_wr_en      = wr_en_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_wr_byte_en = rst_n;
  assign ram_rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_drm_8x1024_arb.sv
// Bench for drm_8x1024_arb: RAM model around the DUT, plus a grant/read-return reference model.
module tb_drm_8x1024_arb;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_wr_en, ram_wr_byte_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  drm_8x1024_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // RAM: 1-cycle read latency, read-before-write on the same edge
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  typedef struct {
    int unsigned   due;
    int            owner;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rd_t           rq[$];
  int            last_w, last_r;
  bit            exp_wr_en;
  logic [AW-1:0] exp_wr_addr, exp_rd_addr;
  logic [DW-1:0] exp_wr_data;
  int unsigned   cyc, n_pass, n_total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic drive(input bit r0, input bit w0, input int a0, input int d0,
                       input bit r1, input bit w1, input int a1, input int d1);
    req0 = r0; we0 = w0; addr0 = AW'(a0); wdata0 = DW'(d0);
    req1 = r1; we1 = w1; addr1 = AW'(a1); wdata1 = DW'(d1);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: inputs already driven just after a falling edge.
  task automatic step(output bit g0, output bit g1);
    bit wr0, wr1, rr0, rr1, gw0, gw1, gr0, gr1, ev0, ev1;
    logic [DW-1:0] ed0, ed1;
    rd_t e;
    #1;
    wr0 = req0 && we0;
    wr1 = req1 && we1;
    if (wr0 && wr1) begin gw0 = (last_w == 1); gw1 = !gw0; end
    else begin gw0 = wr0; gw1 = wr1; end
    rr0 = req0 && !we0 && !(gw1 && addr1 == addr0);
    rr1 = req1 && !we1 && !(gw0 && addr0 == addr1);
    if (rr0 && rr1) begin gr0 = (last_r == 1); gr1 = !gr0; end
    else begin gr0 = rr0; gr1 = rr1; end

    ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
    while (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].owner == 0) begin ev0 = 1; ed0 = rq[0].data; end
      else begin ev1 = 1; ed1 = rq[0].data; end
      void'(rq.pop_front());
    end

    chk("gnt0", 32'(gnt0), 32'(gw0 || gr0));
    chk("gnt1", 32'(gnt1), 32'(gw1 || gr1));
    chk("rvalid0", 32'(rvalid0), 32'(ev0));
    chk("rvalid1", 32'(rvalid1), 32'(ev1));
    chk("rdata0", 32'(rdata0), 32'(ed0));
    chk("rdata1", 32'(rdata1), 32'(ed1));
    chk("ram_wr_en", 32'(ram_wr_en), 32'(exp_wr_en));
    if (exp_wr_en) begin
      chk("ram_wr_addr", 32'(ram_wr_addr), 32'(exp_wr_addr));
      chk("ram_wr_data", 32'(ram_wr_data), 32'(exp_wr_data));
    end
    chk("ram_rd_addr", 32'(ram_rd_addr), 32'(exp_rd_addr));
    chk("ram_wr_byte_en", 32'(ram_wr_byte_en), 32'd1);

    if (gr0 || gr1) begin
      e.due   = cyc + 2;
      e.owner = gr1 ? 1 : 0;
      exp_rd_addr = gr1 ? addr1 : addr0;
      e.data  = ref_mem[exp_rd_addr];
      rq.push_back(e);
      last_r = e.owner;
    end
    exp_wr_en = gw0 || gw1;
    if (exp_wr_en) begin
      exp_wr_addr = gw1 ? addr1 : addr0;
      exp_wr_data = gw1 ? wdata1 : wdata0;
      ref_mem[exp_wr_addr] = exp_wr_data;
      last_w = gw1 ? 1 : 0;
    end
    g0 = gw0 || gr0;
    g1 = gw1 || gr1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n = 1'b0;
    idle();
    repeat (n) begin
      #1;
      chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
      chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
      chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
      chk("rst_wr", 32'({ram_wr_en, ram_wr_byte_en, ram_wr_addr, ram_wr_data}), 32'd0);
      chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
    rq.delete();
    last_w = 1; last_r = 1;
    exp_wr_en = 0; exp_rd_addr = '0;
  endtask

  initial begin
    bit g0, g1, p0, p1, pw0, pw1;
    int pa0, pa1, pd0, pd1;
    for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    cyc = 0; n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    do_reset(3);

    // write/read-back of the whole array
    for (int i = 0; i < DEPTH; i++) begin drive(1, 1, i, 255 - i, 0, 0, 0, 0); step(g0, g1); end
    for (int i = 0; i < DEPTH; i++) begin drive(1, 0, i, 0, 0, 0, 0, 0); step(g0, g1); end
    idle(); repeat (3) step(g0, g1);

    // write contention straight after reset: alternates starting with requester 0
    do_reset(2);
    for (int i = 0; i < 4; i++) begin drive(1, 1, 5, 8'hAA, 1, 1, 6, 8'h55); step(g0, g1); end
    idle(); step(g0, g1);

    // write and read on different ports in the same cycle
    drive(1, 1, 3, 8'h11, 1, 0, 4, 0); step(g0, g1);
    idle(); repeat (3) step(g0, g1);

    // same-address collision: read deferred one cycle, returns new data
    drive(1, 1, 7, 8'h3C, 1, 0, 7, 0); step(g0, g1);
    drive(0, 0, 0, 0, 1, 0, 7, 0); step(g0, g1);
    idle(); repeat (3) step(g0, g1);

    // address wrap
    drive(1, 1, DEPTH - 1, 8'h01, 0, 0, 0, 0); step(g0, g1);
    drive(0, 0, 0, 0, 1, 1, 0, 8'hFE); step(g0, g1);
    drive(1, 0, DEPTH - 1, 0, 0, 0, 0, 0); step(g0, g1);
    drive(0, 0, 0, 0, 1, 0, 0, 0); step(g0, g1);
    idle(); repeat (3) step(g0, g1);

    // reset while a read is in flight
    drive(1, 0, 5, 0, 0, 0, 0, 0); step(g0, g1);
    do_reset(3);
    idle(); repeat (4) step(g0, g1);

    // randomized traffic over a small address pool; requests held until granted
    p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; pw0 = 1'($urandom_range(0, 1)); pd0 = int'($urandom_range(0, 255));
        pa0 = int'($urandom_range(0, 4)); if (pa0 == 4) pa0 = DEPTH - 1;
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1; pw1 = 1'($urandom_range(0, 1)); pd1 = int'($urandom_range(0, 255));
        pa1 = int'($urandom_range(0, 4)); if (pa1 == 4) pa1 = DEPTH - 1;
      end
      drive(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
      step(g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    idle(); repeat (3) step(g0, g1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
